// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - elastic add/subtract pipeline, one WIDTH/STAGES-bit carry slice per stage
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iCarry,
   input  logic             iSub,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oSum,
   output logic             oCarry,
   output logic             oOverflow
);

   localparam int SW = WIDTH / STAGES;

   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] vld_d;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] c_d;
   logic [STAGES-1:0] cin;
   logic [WIDTH-1:0]  a_q    [STAGES];
   logic [WIDTH-1:0]  a_d    [STAGES];
   logic [WIDTH-1:0]  b_q    [STAGES];
   logic [WIDTH-1:0]  b_d    [STAGES];
   logic [WIDTH-1:0]  sum_q  [STAGES];
   logic [WIDTH-1:0]  sum_in [STAGES];
   logic [WIDTH-1:0]  sum_d  [STAGES];
   logic [SW+1:0]     res    [STAGES];
   logic              ovf_q;
   logic              ovf_d;

   // Returns {signed overflow, carry-out, slice sum}; overflow only matters for the top slice.
   function automatic logic [SW+1:0] add_slice(input logic [SW-1:0] a,
                                                input logic [SW-1:0] b,
                                                input logic          ci);
      logic [SW:0] s;
      s = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
      return {s[SW] ^ (s[SW-1] ^ a[SW-1] ^ b[SW-1]), s};
   endfunction

   always_comb begin
      adv[STAGES-1] = !vld_q[STAGES-1] || iReady;
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k] = !vld_q[k] || adv[k+1];
      end
   end

   assign oReady = adv[0];

   // Subtraction is folded in at entry: B is inverted once and travels inverted.
   always_comb begin
      a_d[0]    = iA;
      b_d[0]    = iSub ? ~iB : iB;
      cin[0]    = iCarry ^ iSub;
      sum_in[0] = '0;
      vld_d[0]  = iValid;
      for (int k = 1; k < STAGES; k++) begin
         a_d[k]    = a_q[k-1];
         b_d[k]    = b_q[k-1];
         cin[k]    = c_q[k-1];
         sum_in[k] = sum_q[k-1];
         vld_d[k]  = vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         res[k]                = add_slice(a_d[k][k*SW +: SW], b_d[k][k*SW +: SW], cin[k]);
         sum_d[k]              = sum_in[k];
         sum_d[k][k*SW +: SW]  = res[k][SW-1:0];
         c_d[k]                = res[k][SW];
      end
      ovf_d = res[STAGES-1][SW+1];
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         vld_q <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               vld_q[k] <= vld_d[k];
               if (vld_d[k]) begin
                  a_q[k]   <= a_d[k];
                  b_q[k]   <= b_d[k];
                  sum_q[k] <= sum_d[k];
                  c_q[k]   <= c_d[k];
               end
            end
         end
         if (adv[STAGES-1] && vld_d[STAGES-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign oValid    = vld_q[STAGES-1];
   assign oSum      = sum_q[STAGES-1];
   assign oCarry    = c_q[STAGES-1];
   assign oOverflow = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and table-driven checks for pipelined_adder
module tb_pipelined_adder;

   typedef struct packed {
      logic        ov;
      logic        co;
      logic [15:0] sum;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic        sub;
      logic [15:0] sum;
      logic        co;
      logic        ov;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        iValid, oReady, oValid, iReady, iCarry, iSub, oCarry, oOverflow;
   logic [15:0] iA, iB, oSum;
   logic        v8, r8o, ov8, ir8, c8, s8, co8, of8;
   logic [7:0]  a8, b8, sum8;

   int   passed;
   int   total;
   int   res_count;
   logic mon_en;
   exp_t exp_q[$];

   pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
      .iClk(clk), .iRstN(rst_n), .iValid(iValid), .oReady(oReady),
      .iA(iA), .iB(iB), .iCarry(iCarry), .iSub(iSub),
      .oValid(oValid), .iReady(iReady), .oSum(oSum), .oCarry(oCarry), .oOverflow(oOverflow)
   );

   pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
      .iClk(clk), .iRstN(rst_n), .iValid(v8), .oReady(r8o),
      .iA(a8), .iB(b8), .iCarry(c8), .iSub(s8),
      .oValid(ov8), .iReady(ir8), .oSum(sum8), .oCarry(co8), .oOverflow(of8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input logic sub);
      int   u;
      int   r;
      exp_t e;
      if (!sub) begin
         u = int'(a) + int'(b) + int'(c);
         r = int'($signed(a)) + int'($signed(b)) + int'(c);
         e.co = (u > 65535);
      end else begin
         u = int'(a) - int'(b) - int'(c);
         r = int'($signed(a)) - int'($signed(b)) - int'(c);
         e.co = (u >= 0);
      end
      e.sum = u[15:0];
      e.ov  = (r > 32767) || (r < -32768);
      return e;
   endfunction

   always @(negedge clk) begin
      if (mon_en && rst_n && oValid && iReady) begin
         res_count++;
         if (exp_q.size() == 0) begin
            chk("unexpected_result", {14'd0, oOverflow, oCarry, oSum}, 32'hFFFF_FFFF);
         end else begin
            chk("result", {14'd0, oOverflow, oCarry, oSum}, {14'd0, exp_q[0]});
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic sub, input exp_t e, output int waits);
      iA = a; iB = b; iCarry = c; iSub = sub; iValid = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!oReady && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (oReady) exp_q.push_back(e);
      else chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      iValid = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk); #1;
      chk("drain_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      vec_t        tbl[10];
      logic [15:0] bp_a[6];
      logic [15:0] bp_b[6];
      int          w, stalls, base, idx;
      exp_t        e;

      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[7] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      tbl[9] = '{16'h0F0F, 16'h0F0F, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         bp_a[i] = 16'h1111 * 16'(i + 1);
         bp_b[i] = 16'h0F00 + 16'(i);
      end

      passed = 0; total = 0; res_count = 0; mon_en = 1'b0;
      rst_n = 1'b0; iValid = 1'b0; iReady = 1'b0;
      iA = '0; iB = '0; iCarry = 1'b0; iSub = 1'b0;
      v8 = 1'b0; ir8 = 1'b1; a8 = '0; b8 = '0; c8 = 1'b0; s8 = 1'b0;

      #3;
      chk("rst_valid", oValid, 0);
      chk("rst_outputs", {oOverflow, oCarry, oSum}, 0);
      chk("rst_ready", oReady, 1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      iReady = 1'b1;

      // Single op: exactly four cycles of latency.
      iA = 16'hFFFF; iB = 16'h0001; iCarry = 1'b0; iSub = 1'b0; iValid = 1'b1;
      @(posedge clk); #1;
      iValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lat_early_valid", oValid, 0);
      end
      @(negedge clk);
      chk("lat_valid", oValid, 1);
      chk("lat_wrap_result", {oOverflow, oCarry, oSum}, {1'b0, 1'b1, 16'h0000});
      @(posedge clk); #1;

      mon_en = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sub, '{tbl[i].ov, tbl[i].co, tbl[i].sum}, w);
      end
      wait_drain(20);

      // Backpressure: six ops offered against a stalled sink.
      iReady = 1'b0;
      base = res_count;
      idx = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         iA = bp_a[idx % 6]; iB = bp_b[idx % 6]; iCarry = idx[0]; iSub = idx[1];
         iValid = (idx < 6);
         @(negedge clk);
         if (iValid && oReady) begin
            exp_q.push_back(model(iA, iB, iCarry, iSub));
            idx++;
         end
         @(posedge clk); #1;
      end
      chk("bp_accepted", idx, 4);
      @(negedge clk);
      chk("bp_ready_low", oReady, 0);
      chk("bp_frozen_valid", oValid, 1);
      chk("bp_frozen_result", {oOverflow, oCarry, oSum}, exp_q[0]);
      @(posedge clk); #1;
      iReady = 1'b1;
      @(negedge clk);
      chk("bp_accept_on_drain", oReady, 1);
      if (oReady) begin
         exp_q.push_back(model(iA, iB, iCarry, iSub));
         idx++;
      end
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 10 && idx < 6; cyc++) begin
         iA = bp_a[idx]; iB = bp_b[idx]; iCarry = idx[0]; iSub = idx[1];
         @(negedge clk);
         if (oReady) begin
            exp_q.push_back(model(iA, iB, iCarry, iSub));
            idx++;
         end
         @(posedge clk); #1;
      end
      iValid = 1'b0;
      wait_drain(20);
      chk("bp_result_count", res_count - base, 6);

      // Full throughput with random operands.
      base = res_count;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         logic [15:0] ra, rb;
         logic        rc, rs;
         ra = 16'($urandom); rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         e = model(ra, rb, rc, rs);
         send(ra, rb, rc, rs, e, w);
         stalls += w;
      end
      wait_drain(6);
      chk("tp_result_count", res_count - base, 100);
      chk("tp_stalls", stalls, 0);

      // Reset while three ops are in flight.
      mon_en = 1'b0;
      for (int i = 0; i < 3; i++) send(16'h0100 * 16'(i + 1), 16'h0001, 1'b0, 1'b0, '0, w);
      @(posedge clk); #1;
      chk("midrst_pre_valid", oValid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", oValid, 0);
      chk("midrst_outputs", {oOverflow, oCarry, oSum}, 0);
      chk("midrst_ready", oReady, 1);
      @(posedge clk); #3;
      rst_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst_no_stale", oValid, 0);
      end
      @(posedge clk); #1;
      mon_en = 1'b1;
      base = res_count;
      send(16'h4000, 16'h4000, 1'b0, 1'b0, '{1'b1, 1'b0, 16'h8000}, w);
      wait_drain(10);
      chk("midrst_post_count", res_count - base, 1);

      // Single-stage, 8-bit instance.
      @(posedge clk); #1;
      a8 = 8'h80; b8 = 8'h80; c8 = 1'b1; s8 = 1'b0; v8 = 1'b1;
      @(negedge clk);
      chk("s1_pre_valid", ov8, 0);
      chk("s1_ready", r8o, 1);
      @(posedge clk); #1;
      a8 = 8'h01; b8 = 8'h02; c8 = 1'b0; s8 = 1'b1;
      @(negedge clk);
      chk("s1_valid", ov8, 1);
      chk("s1_result", {of8, co8, sum8}, {1'b1, 1'b1, 8'h01});
      @(posedge clk); #1;
      v8 = 1'b0;
      @(negedge clk);
      chk("s1_sub_result", {ov8, of8, co8, sum8}, {1'b1, 1'b0, 1'b0, 8'hFF});
      @(posedge clk); #1;
      @(negedge clk);
      chk("s1_idle_valid", ov8, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits (>=1).
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth in register stages (>=1, WIDTH % STAGES == 0).
REQ-003 SHALL have port iClk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port iRstN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port iValid  input  1  operand set presented this cycle.
REQ-006 SHALL have port oReady  output  1  block accepts operands this cycle.
REQ-007 SHALL have port iA  input  WIDTH  operand A.
REQ-008 SHALL have port iB  input  WIDTH  operand B.
REQ-009 SHALL have port iCarry  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 SHALL have port iSub  input  1  0 = A+B+iCarry, 1 = A-B-iCarry.
REQ-011 SHALL have port oValid  output  1  result present on outputs.
REQ-012 SHALL have port iReady  input  1  downstream consumes result this cycle.
REQ-013 SHALL have port oSum  output  WIDTH  result.
REQ-014 SHALL have port oCarry  output  1  raw carry-out of MSB (subtract: 1 = no borrow).
REQ-015 SHALL have port oOverflow  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL compute A + (iSub ? ~B : B) + (iCarry XOR iSub), modulo 2^WIDTH, carry-out to oCarry.
REQ-017 SHALL set oOverflow = carry into MSB XOR carry out of MSB.
REQ-018 SHALL split the add into STAGES slices of WIDTH/STAGES bits, slice k (LSB first) resolved in stage k, inter-slice carry registered between stages.
REQ-019 SHALL delay unprocessed operand slices and already-resolved sum slices alongside each stage so oSum, oCarry, oOverflow emerge aligned.
REQ-020 SHALL hold a per-stage valid bit; transfer in occurs when iValid && oReady, out when oValid && iReady.
REQ-021 SHALL give latency of exactly STAGES cycles from accepted input to oValid with no stall.
REQ-022 SHALL sustain one transfer per cycle when iReady stays high.
REQ-023 SHALL advance stage k when it is empty or stage k+1 advances (last stage: when empty or iReady); oReady = stage 0 advance condition.
REQ-024 SHALL hold all stage contents and outputs stable while oValid && !iReady; no result dropped or duplicated.
REQ-025 SHALL accept a new input in the same cycle the last result leaves when pipeline is full and iReady is high.
REQ-026 SHALL ignore iA, iB, iCarry, iSub when iValid is low or oReady is low.
REQ-027 SHALL keep per-transaction iSub/iCarry with that transaction; mixed add/subtract streams allowed back-to-back.
REQ-028 SHALL, with STAGES == 1, be a single registered stage (latency 1).
REQ-029 SHALL keep oReady combinational from iReady and stage valids only (no dependency on iValid).

Reset
REQ-030 SHALL on iRstN low, immediately clear all stage valid bits: oValid = 0, oSum = 0, oCarry = 0, oOverflow = 0.
REQ-031 SHALL drive oReady = 1 while in reset and after release, independent of iReady.
REQ-032 SHALL discard all in-flight transactions on reset mid-operation; first post-reset result derives only from post-reset inputs.

Verification (WIDTH=16, STAGES=4 unless stated)
REQ-033 SHALL verify add wrap: A=0xFFFF, B=0x0001, iCarry=0, iSub=0 -> 4 cycles later oSum=0x0000, oCarry=1, oOverflow=0, oValid=1.
REQ-034 SHALL verify subtract and overflow: A=0x0005, B=0x0007, iSub=1 -> oSum=0xFFFE, oCarry=0, oOverflow=0; next A=0x7FFF, B=0x0001, iSub=0 -> oSum=0x8000, oOverflow=1.
REQ-035 SHALL verify backpressure: iReady=0, stream 6 ops -> exactly 4 accepted, oReady=0 thereafter, outputs frozen; iReady=1 -> all 4 results in order, then remaining 2, none lost.
REQ-036 SHALL verify full throughput: 100 random ops with iValid=iReady=1 -> 100 results, one per cycle after 4-cycle fill, all matching reference model (sum, carry, overflow).
REQ-037 SHALL verify reset mid-op: 3 ops in flight, pulse iRstN low asynchronously between edges -> oValid=0 immediately, no stale result after release.
REQ-038 SHALL verify STAGES=1, WIDTH=8: A=0x80, B=0x80, iCarry=1 -> next cycle oSum=0x01, oCarry=1, oOverflow=1.
